// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the IF/DM memory port arbiter.
package mem_arb_pkg;

  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;
  typedef enum logic {OWN_IF = 1'b0, OWN_DM = 1'b1} owner_t;

  localparam logic [1:0] LEN_BYTE = 2'b00;
  localparam logic [1:0] LEN_HALF = 2'b01;
  localparam logic [1:0] LEN_WORD = 2'b10;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  length;
    logic        sign;
  } mem_req_t;

  // Instruction fetches are always unsigned word reads.
  function automatic mem_req_t fetch_req(input logic [31:0] addr);
    mem_req_t r;
    r.wr     = 1'b0;
    r.addr   = addr;
    r.wdata  = '0;
    r.length = LEN_WORD;
    r.sign   = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester handshakes plus memory-side controls for mem_port_arbiter.
interface mem_port_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;

  logic        dm_req;
  logic        dm_wr;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [1:0]  dm_length;
  logic        dm_sign;
  logic        dm_gnt;
  logic        dm_rvalid;
  logic [31:0] dm_rdata;

  logic        mem_enable;
  logic        mem_wr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [1:0]  mem_length;
  logic        mem_sign;
  logic [31:0] mem_rdata;

  logic        busy;

  modport slave (
    input  if_req, if_addr,
    input  dm_req, dm_wr, dm_addr, dm_wdata, dm_length, dm_sign,
    input  mem_rdata,
    output if_gnt, if_rvalid, if_rdata,
    output dm_gnt, dm_rvalid, dm_rdata,
    output mem_enable, mem_wr, mem_addr, mem_wdata, mem_length, mem_sign,
    output busy
  );

  modport master (
    output if_req, if_addr,
    output dm_req, dm_wr, dm_addr, dm_wdata, dm_length, dm_sign,
    output mem_rdata,
    input  if_gnt, if_rvalid, if_rdata,
    input  dm_gnt, dm_rvalid, dm_rdata,
    input  mem_enable, mem_wr, mem_addr, mem_wdata, mem_length, mem_sign,
    input  busy
  );
endinterface

// File: rtl/mem_port_arbiter_arb2.sv
// Combinational 2-way selector: fixed DM priority or alternating round-robin.
module arb2
  import mem_arb_pkg::*;
(
  input  logic [1:0] i_req,
  input  owner_t     i_last_winner,
  input  logic       i_prio_mode,
  output logic [1:0] o_grant
);

  // Bit 0 is IF, bit 1 is DM.
  always_comb begin
    o_grant = '0;
    unique case (i_req)
      2'b01:   o_grant = 2'b01;
      2'b10:   o_grant = 2'b10;
      2'b11:   o_grant = (i_prio_mode || i_last_winner == OWN_IF) ? 2'b10 : 2'b01;
      default: o_grant = '0;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one byte-addressed memory between the fetch (IF) and load/store (DM) ports.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter bit          PRIO_DATA   = 1'b1
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);

  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

  state_t      r_state;
  owner_t      r_owner;
  owner_t      r_last_winner;
  logic [3:0]  r_cnt;
  mem_req_t    r_req;
  logic        r_if_rvalid;
  logic        r_dm_rvalid;
  logic [31:0] r_if_rdata;
  logic [31:0] r_dm_rdata;

  logic [1:0]  w_grant;
  logic        w_can_grant;
  mem_req_t    w_dm_req;

  arb2 u_arb2 (
    .i_req        ({bus.dm_req, bus.if_req}),
    .i_last_winner(r_last_winner),
    .i_prio_mode  (PRIO_DATA),
    .o_grant      (w_grant)
  );

  // Grants are suppressed while rst is high so nothing is accepted and then dropped.
  assign w_can_grant = (r_state == IDLE) && !rst;
  assign bus.if_gnt  = w_can_grant && w_grant[0];
  assign bus.dm_gnt  = w_can_grant && w_grant[1];

  assign w_dm_req = '{wr:     bus.dm_wr,
                      addr:   bus.dm_addr,
                      wdata:  bus.dm_wdata,
                      length: bus.dm_length,
                      sign:   bus.dm_sign};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_owner       <= OWN_IF;
      r_last_winner <= OWN_IF;
      r_cnt         <= '0;
      r_req         <= '0;
      r_if_rvalid   <= 1'b0;
      r_dm_rvalid   <= 1'b0;
      r_if_rdata    <= '0;
      r_dm_rdata    <= '0;
    end else begin
      r_if_rvalid <= 1'b0;
      r_dm_rvalid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_grant != '0) begin
            r_state <= ACCESS;
            r_cnt   <= CNT_LOAD;
            if (w_grant[1]) begin
              r_owner       <= OWN_DM;
              r_last_winner <= OWN_DM;
              r_req         <= w_dm_req;
            end else begin
              r_owner       <= OWN_IF;
              r_last_winner <= OWN_IF;
              r_req         <= fetch_req(bus.if_addr);
            end
          end
        end
        ACCESS: begin
          if (r_cnt == '0) begin
            // Clearing the latched fields is what returns mem_* to 0 in IDLE.
            r_state <= IDLE;
            r_req   <= '0;
            if (r_owner == OWN_DM) begin
              r_dm_rvalid <= 1'b1;
              r_dm_rdata  <= r_req.wr ? '0 : bus.mem_rdata;
            end else begin
              r_if_rvalid <= 1'b1;
              r_if_rdata  <= bus.mem_rdata;
            end
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
      endcase
    end
  end

  assign bus.mem_enable = (r_state == ACCESS);
  assign bus.busy       = (r_state == ACCESS);
  assign bus.mem_wr     = r_req.wr;
  assign bus.mem_addr   = r_req.addr;
  assign bus.mem_wdata  = r_req.wdata;
  assign bus.mem_length = r_req.length;
  assign bus.mem_sign   = r_req.sign;

  assign bus.if_rvalid = r_if_rvalid;
  assign bus.if_rdata  = r_if_rdata;
  assign bus.dm_rvalid = r_dm_rvalid;
  assign bus.dm_rdata  = r_dm_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: dut_a (WAIT_CYCLES=1, DM priority), dut_b (WAIT_CYCLES=3, round-robin).
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned n_cmp = 0;
  int unsigned n_mis = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if bus_a ();
  mem_port_arbiter_if bus_b ();

  mem_port_arbiter #(.WAIT_CYCLES(1), .PRIO_DATA(1'b1)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  mem_port_arbiter #(.WAIT_CYCLES(3), .PRIO_DATA(1'b0)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  logic [7:0] mem_a [256];
  logic [7:0] mem_b [256];
  logic [7:0] wa_a, wa_b;

  function automatic logic [31:0] rd_fmt(input logic en, input logic [7:0] b0, input logic [7:0] b1,
                                         input logic [7:0] b2, input logic [7:0] b3,
                                         input logic [1:0] len, input logic sgn);
    if (!en) return '0;
    case (len)
      2'b00:   return sgn ? {{24{b0[7]}}, b0} : {24'h0, b0};
      2'b01:   return sgn ? {{16{b1[7]}}, b1, b0} : {16'h0, b1, b0};
      2'b10:   return {b3, b2, b1, b0};
      default: return '0;
    endcase
  endfunction

  assign wa_a = bus_a.mem_addr[7:0];
  assign wa_b = bus_b.mem_addr[7:0];
  assign bus_a.mem_rdata = rd_fmt(bus_a.mem_enable, mem_a[wa_a], mem_a[8'(wa_a + 8'd1)],
                                  mem_a[8'(wa_a + 8'd2)], mem_a[8'(wa_a + 8'd3)],
                                  bus_a.mem_length, bus_a.mem_sign);
  assign bus_b.mem_rdata = rd_fmt(bus_b.mem_enable, mem_b[wa_b], mem_b[8'(wa_b + 8'd1)],
                                  mem_b[8'(wa_b + 8'd2)], mem_b[8'(wa_b + 8'd3)],
                                  bus_b.mem_length, bus_b.mem_sign);

  always @(negedge clk) begin
    if (bus_b.mem_enable && bus_b.mem_wr) begin
      case (bus_b.mem_length)
        2'b00: mem_b[wa_b] <= bus_b.mem_wdata[7:0];
        2'b01: begin
          mem_b[wa_b]            <= bus_b.mem_wdata[7:0];
          mem_b[8'(wa_b + 8'd1)] <= bus_b.mem_wdata[15:8];
        end
        2'b10: begin
          mem_b[wa_b]            <= bus_b.mem_wdata[7:0];
          mem_b[8'(wa_b + 8'd1)] <= bus_b.mem_wdata[15:8];
          mem_b[8'(wa_b + 8'd2)] <= bus_b.mem_wdata[23:16];
          mem_b[8'(wa_b + 8'd3)] <= bus_b.mem_wdata[31:24];
        end
        default: ;
      endcase
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic wait_gnt_b(output logic [1:0] g);
    g = 2'b00;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus_b.if_gnt || bus_b.dm_gnt) begin
        g = {bus_b.dm_gnt, bus_b.if_gnt};
        break;
      end
    end
  endtask

  task automatic set_dm_a(input logic req, input logic wr, input logic [31:0] addr,
                          input logic [1:0] len, input logic sgn);
    bus_a.dm_req = req; bus_a.dm_wr = wr; bus_a.dm_addr = addr;
    bus_a.dm_wdata = '0; bus_a.dm_length = len; bus_a.dm_sign = sgn;
  endtask

  task automatic set_dm_b(input logic req, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [1:0] len, input logic sgn);
    bus_b.dm_req = req; bus_b.dm_wr = wr; bus_b.dm_addr = addr;
    bus_b.dm_wdata = wdata; bus_b.dm_length = len; bus_b.dm_sign = sgn;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0] g;
    logic [1:0] rr_exp [4];
    rr_exp = '{2'b10, 2'b01, 2'b10, 2'b01};

    for (int i = 0; i < 256; i++) begin
      mem_a[i] = '0;
      mem_b[i] = '0;
    end
    {mem_a[8'h13], mem_a[8'h12], mem_a[8'h11], mem_a[8'h10]} = 32'hDEADBEEF;
    {mem_a[8'h43], mem_a[8'h42], mem_a[8'h41], mem_a[8'h40]} = 32'h11223344;
    {mem_b[8'h37], mem_b[8'h36], mem_b[8'h35], mem_b[8'h34]} = 32'hCAFEF00D;

    bus_a.if_req = 1'b1; bus_a.if_addr = 32'h10;
    set_dm_a(1'b0, 1'b0, '0, 2'b00, 1'b0);
    bus_b.if_req = 1'b0; bus_b.if_addr = '0;
    set_dm_b(1'b0, 1'b0, '0, '0, 2'b00, 1'b0);

    // Reset held with a pending fetch
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_if_gnt", bus_a.if_gnt, 0);
      chk("rst_mem_en", bus_a.mem_enable, 0);
      chk("rst_rvalid", {bus_a.if_rvalid, bus_a.dm_rvalid, bus_b.if_rvalid, bus_b.dm_rvalid}, 0);
      @(posedge clk);
    end
    #1 rst = 1'b0;

    // Single fetch, WAIT_CYCLES=1
    @(negedge clk);
    chk("f_if_gnt", bus_a.if_gnt, 1);
    chk("f_dm_gnt", bus_a.dm_gnt, 0);
    chk("f_en_idle", bus_a.mem_enable, 0);
    @(posedge clk); #1 bus_a.if_req = 1'b0;
    @(negedge clk);
    chk("f_en", bus_a.mem_enable, 1);
    chk("f_addr", bus_a.mem_addr, 32'h10);
    chk("f_len", bus_a.mem_length, 2'b10);
    chk("f_wr", bus_a.mem_wr, 0);
    chk("f_busy", bus_a.busy, 1);
    chk("f_rv_early", bus_a.if_rvalid, 0);
    @(posedge clk); @(negedge clk);
    chk("f_rvalid", bus_a.if_rvalid, 1);
    chk("f_rdata", bus_a.if_rdata, 32'hDEADBEEF);
    chk("f_en_off", bus_a.mem_enable, 0);
    @(posedge clk); @(negedge clk);
    chk("f_rv_pulse", bus_a.if_rvalid, 0);
    chk("f_rdata_hold", bus_a.if_rdata, 32'hDEADBEEF);

    // Fixed priority: DM first, IF granted in the dm_rvalid cycle
    @(posedge clk); #1;
    bus_a.if_req = 1'b1; bus_a.if_addr = 32'h10;
    set_dm_a(1'b1, 1'b0, 32'h40, 2'b10, 1'b0);
    @(negedge clk);
    chk("p_dm_gnt", bus_a.dm_gnt, 1);
    chk("p_if_gnt", bus_a.if_gnt, 0);
    @(posedge clk); #1 bus_a.dm_req = 1'b0;
    @(negedge clk);
    chk("p_busy", bus_a.busy, 1);
    chk("p_if_gnt_busy", bus_a.if_gnt, 0);
    @(posedge clk); @(negedge clk);
    chk("p_dm_rvalid", bus_a.dm_rvalid, 1);
    chk("p_dm_rdata", bus_a.dm_rdata, 32'h11223344);
    chk("p_if_gnt_rv", bus_a.if_gnt, 1);
    @(posedge clk); #1 bus_a.if_req = 1'b0;
    @(negedge clk);
    chk("p_if_addr", bus_a.mem_addr, 32'h10);
    @(posedge clk); @(negedge clk);
    chk("p_if_rvalid", bus_a.if_rvalid, 1);

    // Reserved length 11 is forwarded and answered with 0
    @(posedge clk); #1 set_dm_a(1'b1, 1'b0, 32'h40, 2'b11, 1'b0);
    @(negedge clk);
    chk("l11_gnt", bus_a.dm_gnt, 1);
    @(posedge clk); #1 bus_a.dm_req = 1'b0;
    @(negedge clk);
    chk("l11_len", bus_a.mem_length, 2'b11);
    @(posedge clk); @(negedge clk);
    chk("l11_rvalid", bus_a.dm_rvalid, 1);
    chk("l11_rdata", bus_a.dm_rdata, 0);

    // Store byte then signed load byte, WAIT_CYCLES=3
    @(posedge clk); #1 set_dm_b(1'b1, 1'b1, 32'h20, 32'h80, 2'b00, 1'b0);
    @(negedge clk);
    chk("sb_gnt", bus_b.dm_gnt, 1);
    @(posedge clk); #1 bus_b.dm_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("sb_en", bus_b.mem_enable, 1);
      chk("sb_wr", bus_b.mem_wr, 1);
      chk("sb_rv_early", bus_b.dm_rvalid, 0);
      @(posedge clk);
    end
    @(negedge clk);
    chk("sb_rvalid", bus_b.dm_rvalid, 1);
    chk("sb_rdata", bus_b.dm_rdata, 0);
    chk("sb_en_off", bus_b.mem_enable, 0);
    chk("sb_mem", {24'h0, mem_b[8'h20]}, 32'h80);
    @(posedge clk); #1 set_dm_b(1'b1, 1'b0, 32'h20, '0, 2'b00, 1'b1);
    @(negedge clk);
    chk("lb_gnt", bus_b.dm_gnt, 1);
    @(posedge clk); #1 bus_b.dm_req = 1'b0;
    @(negedge clk);
    chk("lb_sign", bus_b.mem_sign, 1);
    chk("lb_len", bus_b.mem_length, 2'b00);
    @(posedge clk); @(posedge clk); @(posedge clk);
    @(negedge clk);
    chk("lb_rvalid", bus_b.dm_rvalid, 1);
    chk("lb_rdata", bus_b.dm_rdata, 32'hFFFFFF80);

    // Round-robin from a fresh reset with both requests held
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    bus_b.if_req = 1'b1; bus_b.if_addr = 32'h30;
    set_dm_b(1'b1, 1'b0, 32'h34, '0, 2'b10, 1'b0);
    for (int k = 0; k < 4; k++) begin
      wait_gnt_b(g);
      chk($sformatf("rr_order%0d", k), g, rr_exp[k]);
    end
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rr_after_rst", {bus_b.dm_gnt, bus_b.if_gnt}, 2'b10);
    @(posedge clk); #1;
    bus_b.if_req = 1'b0; bus_b.dm_req = 1'b0;
    @(posedge clk); @(posedge clk); @(posedge clk);
    @(negedge clk);
    chk("rr_rvalid", bus_b.dm_rvalid, 1);
    chk("rr_rdata", bus_b.dm_rdata, 32'hCAFEF00D);

    // Reset in the 2nd cycle of a 3-cycle load aborts it
    @(posedge clk); #1 set_dm_b(1'b1, 1'b0, 32'h20, '0, 2'b00, 1'b0);
    @(negedge clk);
    chk("ab_gnt", bus_b.dm_gnt, 1);
    @(posedge clk); #1 bus_b.dm_req = 1'b0;
    @(negedge clk);
    chk("ab_en1", bus_b.mem_enable, 1);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("ab_en2", bus_b.mem_enable, 1);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("ab_en_off", bus_b.mem_enable, 0);
    chk("ab_busy", bus_b.busy, 0);
    chk("ab_rdata", bus_b.dm_rdata, 0);
    for (int i = 0; i < 3; i++) begin
      chk("ab_no_rvalid", bus_b.dm_rvalid, 0);
      @(posedge clk); @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
